// File: rtl/ship_input_pkg.sv
// Shared scan codes, key indices and prefix-FSM encoding for the ship input path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: PS/2 set-2 scan-code constants, bitmap index of each ship key,
// prefix FSM state encoding and a scan-code -> key-index lookup helper.
package ship_input_pkg;

  // Protocol bytes
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BAT_OK = 8'hAA;

  // Ship key scan codes (the arrows are only meaningful after E0)
  localparam logic [7:0] SC_A      = 8'h1C;
  localparam logic [7:0] SC_D      = 8'h23;
  localparam logic [7:0] SC_S      = 8'h1B;
  localparam logic [7:0] SC_W      = 8'h1D;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_RIGHT  = 8'h74;

  // Bit position of each key in the held/tapped bitmaps
  localparam int KEY_A     = 0;
  localparam int KEY_D     = 1;
  localparam int KEY_S     = 2;
  localparam int KEY_W     = 3;
  localparam int KEY_SPACE = 4;
  localparam int KEY_UP    = 5;
  localparam int KEY_LEFT  = 6;
  localparam int KEY_DOWN  = 7;
  localparam int KEY_RIGHT = 8;
  localparam int NUM_KEYS  = 9;

  typedef enum logic [1:0] {
    PS_IDLE    = 2'd0,
    PS_EXT     = 2'd1,
    PS_BRK     = 2'd2,
    PS_EXT_BRK = 2'd3
  } prefix_state_t;

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } key_lookup_t;

  // Extended and plain code spaces are disjoint: 75/6B/72/74 without E0 are
  // keypad keys and must not alias onto the arrows.
  function automatic key_lookup_t lookup_key(input logic [7:0] code, input logic ext);
    key_lookup_t r;
    r.hit = 1'b1;
    r.idx = 4'(KEY_A);
    if (!ext) begin
      case (code)
        SC_A:     r.idx = 4'(KEY_A);
        SC_D:     r.idx = 4'(KEY_D);
        SC_S:     r.idx = 4'(KEY_S);
        SC_W:     r.idx = 4'(KEY_W);
        SC_SPACE: r.idx = 4'(KEY_SPACE);
        default:  r.hit = 1'b0;
      endcase
    end else begin
      case (code)
        SC_UP:    r.idx = 4'(KEY_UP);
        SC_LEFT:  r.idx = 4'(KEY_LEFT);
        SC_DOWN:  r.idx = 4'(KEY_DOWN);
        SC_RIGHT: r.idx = 4'(KEY_RIGHT);
        default:  r.hit = 1'b0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/scan_prefix_decoder.sv
// Tracks E0/F0 prefixes of the PS/2 byte stream and emits one key event per completed code.
// Latency: 0 (events are combinational in the cycle of the completing byte).
// Backpressure: none; accepts one byte per cycle, abandons a prefix after PREFIX_TIMEOUT idle cycles.
//
// Ports: i_clk, i_reset (async, active-high), i_rx_data/i_rx_done_tick (byte strobe);
//        o_key_evt with o_key_idx/o_is_break/o_is_ext for table keys, o_bat_ok for AA in IDLE.
module scan_prefix_decoder
  import ship_input_pkg::*;
#(
  parameter int PREFIX_TIMEOUT = 50000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_done_tick,
  output logic       o_key_evt,
  output logic [3:0] o_key_idx,
  output logic       o_is_break,
  output logic       o_is_ext,
  output logic       o_bat_ok
);

  localparam int CW = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;

  prefix_state_t r_state;
  prefix_state_t w_state_nxt;
  logic [CW-1:0] r_to_cnt;
  logic          w_timeout;
  key_lookup_t   w_lk;

  // Counter holds the number of silent cycles already spent in a prefix state;
  // the PREFIX_TIMEOUT-th silent cycle drops back to IDLE.
  assign w_timeout = (r_state != PS_IDLE) && !i_rx_done_tick &&
                     (r_to_cnt == CW'(PREFIX_TIMEOUT - 1));

  assign w_lk = lookup_key(i_rx_data, (r_state == PS_EXT) || (r_state == PS_EXT_BRK));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= PS_IDLE;
      r_to_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == PS_IDLE) || i_rx_done_tick || w_timeout) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_rx_done_tick) begin
      case (r_state)
        PS_IDLE: begin
          if (i_rx_data == SC_EXT)        w_state_nxt = PS_EXT;
          else if (i_rx_data == SC_BREAK) w_state_nxt = PS_BRK;
        end
        PS_EXT:  w_state_nxt = (i_rx_data == SC_BREAK) ? PS_EXT_BRK : PS_IDLE;
        // In a break state every byte, including E0, is the awaited key byte.
        default: w_state_nxt = PS_IDLE;
      endcase
    end else if (w_timeout) begin
      w_state_nxt = PS_IDLE;
    end
  end

  always_comb begin
    o_key_evt  = 1'b0;
    o_is_break = 1'b0;
    o_is_ext   = 1'b0;
    o_bat_ok   = 1'b0;
    o_key_idx  = w_lk.idx;
    if (i_rx_done_tick) begin
      case (r_state)
        PS_IDLE: begin
          if (i_rx_data == SC_BAT_OK) begin
            o_bat_ok = 1'b1;
          end else if ((i_rx_data != SC_EXT) && (i_rx_data != SC_BREAK)) begin
            o_key_evt = w_lk.hit;
          end
        end
        PS_EXT: begin
          if (i_rx_data != SC_BREAK) begin
            o_key_evt = w_lk.hit;
            o_is_ext  = 1'b1;
          end
        end
        PS_BRK: begin
          o_key_evt  = w_lk.hit;
          o_is_break = 1'b1;
        end
        default: begin
          o_key_evt  = w_lk.hit;
          o_is_break = 1'b1;
          o_is_ext   = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/ship_input_ctrl.sv
// Frame-synchronous ship control scheduler: key bitmaps from PS/2 bytes, latched once per frame, fire metered by cooldown.
// Latency: control outputs and ctrl_valid update 1 cycle after frame_tick; bitmap updates 1 cycle after rx_done_tick.
// Backpressure: none; accepts one byte per cycle, no ready signal.
//
// Ports: i_clk, i_reset (async, active-high), i_rx_data/i_rx_done_tick (receiver bytes),
//        i_frame_tick (frame strobe); o_p1_ctrl/o_p2_ctrl {up,down,right,left}, o_fire_pulse,
//        o_ctrl_valid, o_kbd_reset_seen (sticky BAT-passed flag).
// Build option: define SHIP_INPUT_P2_EN to decode the player-2 arrow keys; otherwise o_p2_ctrl is 0.
module ship_input_ctrl
  import ship_input_pkg::*;
#(
  parameter int FIRE_COOLDOWN  = 8,
  parameter int PREFIX_TIMEOUT = 50000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_done_tick,
  input  logic       i_frame_tick,
  output logic [3:0] o_p1_ctrl,
  output logic [3:0] o_p2_ctrl,
  output logic       o_fire_pulse,
  output logic       o_ctrl_valid,
  output logic       o_kbd_reset_seen
);

`ifdef SHIP_INPUT_P2_EN
  localparam bit P2_EN = 1'b1;
  localparam int NK    = NUM_KEYS;
`else
  localparam bit P2_EN = 1'b0;
  localparam int NK    = KEY_SPACE + 1;
`endif

  logic          w_key_evt, w_is_break, w_is_ext, w_bat_ok, w_evt_use, w_fire;
  logic [3:0]    w_key_idx;
  logic [NK-1:0] r_held, r_tapped, w_held_nxt, w_tapped_nxt, w_key_mask, w_vis;
  logic [7:0]    r_cooldown;
  logic [3:0]    r_p1;
  logic          r_fire, r_valid, r_kbd;

  scan_prefix_decoder #(
    .PREFIX_TIMEOUT(PREFIX_TIMEOUT)
  ) u_dec (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_rx_data     (i_rx_data),
    .i_rx_done_tick(i_rx_done_tick),
    .o_key_evt     (w_key_evt),
    .o_key_idx     (w_key_idx),
    .o_is_break    (w_is_break),
    .o_is_ext      (w_is_ext),
    .o_bat_ok      (w_bat_ok)
  );

  // Without player 2 the extended keys have no bitmap slot; drop their events.
  assign w_evt_use  = w_key_evt & (P2_EN | ~w_is_ext);
  assign w_key_mask = w_evt_use ? (NK'(1) << w_key_idx) : '0;
  assign w_vis      = r_held | r_tapped;
  assign w_fire     = (r_cooldown == 8'd0) && w_vis[KEY_SPACE];

  // The frame latch reads the registered bitmap, so a byte landing in the frame
  // cycle is applied after the tapped clear and its tap carries to the next frame.
  always_comb begin
    w_held_nxt   = r_held;
    w_tapped_nxt = i_frame_tick ? '0 : r_tapped;
    if (w_bat_ok) begin
      w_held_nxt   = '0;
      w_tapped_nxt = '0;
    end else if (w_is_break) begin
      w_held_nxt = w_held_nxt & ~w_key_mask;
    end else begin
      w_held_nxt   = w_held_nxt | w_key_mask;
      w_tapped_nxt = w_tapped_nxt | w_key_mask;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_held     <= '0;
      r_tapped   <= '0;
      r_cooldown <= '0;
      r_p1       <= '0;
      r_fire     <= 1'b0;
      r_valid    <= 1'b0;
      r_kbd      <= 1'b0;
    end else begin
      r_held   <= w_held_nxt;
      r_tapped <= w_tapped_nxt;
      r_valid  <= i_frame_tick;
      r_fire   <= i_frame_tick & w_fire;
      if (w_bat_ok) r_kbd <= 1'b1;
      if (i_frame_tick) begin
        r_p1 <= {w_vis[KEY_W], w_vis[KEY_S], w_vis[KEY_D], w_vis[KEY_A]};
        if (w_fire)                   r_cooldown <= 8'(FIRE_COOLDOWN - 1);
        else if (r_cooldown != 8'd0)  r_cooldown <= r_cooldown - 8'd1;
      end
    end
  end

`ifdef SHIP_INPUT_P2_EN
  logic [3:0] r_p2;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_p2 <= '0;
    end else if (i_frame_tick) begin
      r_p2 <= {w_vis[KEY_UP], w_vis[KEY_DOWN], w_vis[KEY_RIGHT], w_vis[KEY_LEFT]};
    end
  end
  assign o_p2_ctrl = r_p2;
`else
  assign o_p2_ctrl = 4'b0000;
`endif

  assign o_p1_ctrl        = r_p1;
  assign o_fire_pulse     = r_fire;
  assign o_ctrl_valid     = r_valid;
  assign o_kbd_reset_seen = r_kbd;

endmodule

// File: tb/tb_ship_input_ctrl.sv
// Self-checking bench for ship_input_ctrl: directed vector table, corner sequences, random traffic vs reference model.
module tb_ship_input_ctrl;

  localparam int FC = 8;
  localparam int TO = 40;
`ifdef SHIP_INPUT_P2_EN
  localparam bit P2 = 1'b1;
`else
  localparam bit P2 = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_tick, frame;
  logic [3:0] p1, p2;
  logic       fire, valid, kbd;

  ship_input_ctrl #(.FIRE_COOLDOWN(FC), .PREFIX_TIMEOUT(TO)) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_rx_data       (rx_data),
    .i_rx_done_tick  (rx_tick),
    .i_frame_tick    (frame),
    .o_p1_ctrl       (p1),
    .o_p2_ctrl       (p2),
    .o_fire_pulse    (fire),
    .o_ctrl_valid    (valid),
    .o_kbd_reset_seen(kbd)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model ----------------
  logic [7:0] key_codes [9] = '{8'h1C, 8'h23, 8'h1B, 8'h1D, 8'h29, 8'h75, 8'h6B, 8'h72, 8'h74};
  bit         m_held [9];
  bit         m_tap  [9];
  logic [7:0] m_pfx [$];
  int         m_quiet, m_cd;
  logic [3:0] m_p1, m_p2;
  bit         m_fire, m_valid, m_kbd;

  function automatic int key_of(input logic [7:0] code, input bit ext);
    for (int i = 0; i < 9; i++)
      if (key_codes[i] == code && ((i >= 5) == ext)) return i;
    return -1;
  endfunction

  task automatic apply_key(input int k, input bit brk);
    if (k < 0) return;
    if (!P2 && k >= 5) return;
    if (brk) m_held[k] = 1'b0;
    else begin m_held[k] = 1'b1; m_tap[k] = 1'b1; end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 9; i++) begin m_held[i] = 1'b0; m_tap[i] = 1'b0; end
    m_pfx.delete();
    m_quiet = 0; m_cd = 0;
    m_p1 = 0; m_p2 = 0; m_fire = 0; m_valid = 0; m_kbd = 0;
  endtask

  task automatic model_byte(input logic [7:0] d);
    if (m_pfx.size() == 0) begin
      if (d == 8'hE0 || d == 8'hF0) m_pfx.push_back(d);
      else if (d == 8'hAA) begin
        for (int i = 0; i < 9; i++) begin m_held[i] = 1'b0; m_tap[i] = 1'b0; end
        m_kbd = 1'b1;
      end else apply_key(key_of(d, 1'b0), 1'b0);
    end else if (m_pfx[m_pfx.size()-1] == 8'hF0) begin
      apply_key(key_of(d, m_pfx[0] == 8'hE0), 1'b1);
      m_pfx.delete();
    end else begin
      if (d == 8'hF0) m_pfx.push_back(d);
      else begin
        apply_key(key_of(d, 1'b1), 1'b0);
        m_pfx.delete();
      end
    end
  endtask

  task automatic model_step(input bit r, input logic [7:0] d, input bit f);
    bit v [9];
    m_valid = f;
    m_fire  = 1'b0;
    if (f) begin
      for (int i = 0; i < 9; i++) v[i] = m_held[i] | m_tap[i];
      m_p1 = {v[3], v[2], v[1], v[0]};
      m_p2 = P2 ? {v[5], v[7], v[8], v[6]} : 4'b0000;
      if (m_cd == 0 && v[4]) begin m_fire = 1'b1; m_cd = FC - 1; end
      else if (m_cd > 0) m_cd--;
      for (int i = 0; i < 9; i++) m_tap[i] = 1'b0;
    end
    if (r) begin
      model_byte(d);
      m_quiet = 0;
    end else if (m_pfx.size() != 0) begin
      m_quiet++;
      if (m_quiet >= TO) begin m_pfx.delete(); m_quiet = 0; end
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle(input bit r, input logic [7:0] d, input bit f);
    rx_tick = r; rx_data = d; frame = f;
    @(posedge clk);
    model_step(r, d, f);
    #1;
    chk("cycle_vs_model", {21'd0, p1, p2, fire, valid, kbd},
        {21'd0, m_p1, m_p2, m_fire, m_valid, m_kbd});
    rx_tick = 1'b0; rx_data = 8'h00; frame = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    cycle(1'b1, d, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0);
  endtask

  // Frame strobe plus checks against hand-derived expectations.
  task automatic frame_chk(input string name, input logic [3:0] e1, input logic [3:0] e2, input bit ef);
    cycle(1'b0, 8'h00, 1'b1);
    chk({name, "_valid"}, 32'(valid), 32'd1);
    chk({name, "_p1"},    32'(p1),    32'(e1));
    chk({name, "_p2"},    32'(p2),    32'(e2 & {4{P2}}));
    chk({name, "_fire"},  32'(fire),  32'(ef));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int         nb;
    logic [7:0] b [3];
    logic [3:0] p1;
    logic [3:0] p2;
    bit         fire;
  } vec_t;
  vec_t tbl [13];

  task automatic set_vec(input int i, input int nb, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [3:0] e1, input logic [3:0] e2, input bit ef);
    tbl[i].nb = nb; tbl[i].b[0] = b0; tbl[i].b[1] = b1; tbl[i].b[2] = b2;
    tbl[i].p1 = e1; tbl[i].p2 = e2; tbl[i].fire = ef;
  endtask

  logic [7:0] pool [14] = '{8'h1C, 8'h23, 8'h1B, 8'h1D, 8'h29, 8'h75, 8'h6B,
                            8'h72, 8'h74, 8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'h12};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    rst = 1'b1; rx_tick = 1'b0; rx_data = 8'h00; frame = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_p1",    32'(p1),    32'd0);
    chk("reset_p2",    32'(p2),    32'd0);
    chk("reset_fire",  32'(fire),  32'd0);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_kbd",   32'(kbd),   32'd0);
    rst = 1'b0;
    idle(2);

    set_vec( 0, 1, 8'h1D, 8'h00, 8'h00, 4'b1000, 4'b0000, 1'b0); // W make
    set_vec( 1, 2, 8'hF0, 8'h1D, 8'h00, 4'b0000, 4'b0000, 1'b0); // W break
    set_vec( 2, 2, 8'hE0, 8'h6B, 8'h00, 4'b0000, 4'b0001, 1'b0); // left make
    set_vec( 3, 1, 8'h6B, 8'h00, 8'h00, 4'b0000, 4'b0001, 1'b0); // keypad 4: ignored
    set_vec( 4, 3, 8'hE0, 8'hF0, 8'h6B, 4'b0000, 4'b0000, 1'b0); // left break
    set_vec( 5, 3, 8'h29, 8'hF0, 8'h29, 4'b0000, 4'b0000, 1'b1); // space tap fires
    set_vec( 6, 3, 8'h29, 8'hF0, 8'h29, 4'b0000, 4'b0000, 1'b0); // cooldown blocks
    set_vec( 7, 3, 8'hE0, 8'h75, 8'h1C, 4'b0001, 4'b1000, 1'b0); // up + A
    set_vec( 8, 2, 8'hF0, 8'h1C, 8'h00, 4'b0000, 4'b1000, 1'b0); // A break
    set_vec( 9, 2, 8'hE0, 8'h12, 8'h00, 4'b0000, 4'b1000, 1'b0); // fake shift
    set_vec(10, 3, 8'hE0, 8'hF0, 8'h75, 4'b0000, 4'b0000, 1'b0); // up break
    set_vec(11, 3, 8'hF0, 8'hE0, 8'h1C, 4'b0001, 4'b0000, 1'b0); // E0 consumed as break byte
    set_vec(12, 2, 8'hF0, 8'h1C, 8'h00, 4'b0000, 4'b0000, 1'b0);

    for (int i = 0; i < 13; i++) begin
      for (int j = 0; j < tbl[i].nb; j++) send(tbl[i].b[j]);
      frame_chk($sformatf("vec%0d", i), tbl[i].p1, tbl[i].p2, tbl[i].fire);
    end

    // Fire cadence with space held: frames 0, 8, 16 only.
    for (int i = 0; i < 10; i++) begin idle(1); cycle(1'b0, 8'h00, 1'b1); end
    send(8'h29);
    for (int k = 0; k <= 16; k++) begin
      idle(2);
      frame_chk($sformatf("cadence%0d", k), 4'b0000, 4'b0000, (k % 8) == 0);
    end
    send(8'hF0); send(8'h29);
    cycle(1'b0, 8'h00, 1'b1);

    // Prefix timeout: just inside the window the byte is still extended,
    // after the window it is decoded from IDLE.
    send(8'hE0); idle(TO - 2); send(8'h1C);
    frame_chk("to_inside", 4'b0000, 4'b0000, 1'b0);
    send(8'hE0); idle(TO + 5); send(8'h1C);
    frame_chk("to_expired", 4'b0001, 4'b0000, 1'b0);
    send(8'hE0); idle(TO + 5); send(8'h75);
    frame_chk("to_keypad", 4'b0001, 4'b0000, 1'b0);
    send(8'hF0); send(8'h1C);
    frame_chk("to_release", 4'b0000, 4'b0000, 1'b0);

    // Byte coincident with frame_tick lands after the latch.
    cycle(1'b1, 8'h1C, 1'b1);
    chk("coinc_valid", 32'(valid), 32'd1);
    chk("coinc_p1a",   32'(p1[0]), 32'd0);
    idle(1);
    frame_chk("coinc_next", 4'b0001, 4'b0000, 1'b0);
    send(8'hF0); send(8'h1C);
    frame_chk("coinc_rel", 4'b0000, 4'b0000, 1'b0);

    // Sub-frame tap is seen exactly once.
    send(8'h1D); send(8'hF0); send(8'h1D);
    frame_chk("tap_once", 4'b1000, 4'b0000, 1'b0);
    frame_chk("tap_gone", 4'b0000, 4'b0000, 1'b0);

    // Self-test byte clears held keys and sets the sticky flag.
    send(8'h1D); send(8'h29); send(8'hAA);
    frame_chk("bat", 4'b0000, 4'b0000, 1'b0);
    chk("bat_kbd", 32'(kbd), 32'd1);

    // Reset in the middle of a break prefix discards it.
    send(8'hF0);
    rst = 1'b1;
    #2;
    chk("arst_outputs", {27'd0, p1, fire}, 32'd0);
    chk("arst_kbd", 32'(kbd), 32'd0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    send(8'h23);
    frame_chk("post_reset_d", 4'b0010, 4'b0000, 1'b0);
    send(8'hF0); send(8'h23);
    cycle(1'b0, 8'h00, 1'b1);

    // Random traffic against the model.
    for (int it = 0; it < 4000; it++) begin
      if ($urandom_range(0, 199) == 0) begin
        idle($urandom_range(TO - 3, TO + 3));
      end else begin
        if ($urandom_range(0, 299) == 0)      d = 8'hAA;
        else if ($urandom_range(0, 9) == 0)   d = 8'($urandom);
        else                                  d = pool[$urandom_range(0, 13)];
        cycle($urandom_range(0, 2) == 0, d, $urandom_range(0, 15) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
